// File: rtl/sar_search.sv
// sar_search: successive-approximation (binary) search engine.
//
// Drives the B operand of an external magnitude comparator with `guess` and
// narrows an inclusive [lo, hi] window from the gt/eq/lt flags it returns,
// until the hidden A operand is hit (eq), the window empties, or the
// responder answers with an illegal flag combination.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a search (sampled only when idle)
//   guess      current probe value, to comparator B
//   cmp_valid  gt/eq/lt answer the current guess this cycle
//   gt/eq/lt   target >, ==, < guess
//   busy       search in progress
//   done       one-cycle pulse at the end of a search
//   found      last search ended on eq
//   error      last search ended on an illegal response
//   result     value found (0 when not found)
//   steps      responses consumed by the last or current search
module sar_search #(
  parameter  int WIDTH = 3,
  localparam int SW    = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             cmp_valid,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [SW-1:0]    steps
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Midpoint of the inclusive window; bounds carry one extra bit so that
  // lo = 2^WIDTH (after a gt on the top value) is representable.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] lo,
                                                input logic [WIDTH:0] hi);
    logic [WIDTH:0] mid;
    mid = lo + ((hi - lo) >> 1);
    return mid[WIDTH-1:0];
  endfunction

  // A legal response has exactly one flag set.
  function automatic logic resp_legal(input logic g, input logic e, input logic l);
    return (g & ~e & ~l) | (~g & e & ~l) | (~g & ~e & l);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH:0]   lo_q, lo_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             found_q, found_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    steps_d  = steps_q;
    found_d  = found_q;
    error_d  = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d     = {(WIDTH+1){1'b0}};
          hi_d     = {1'b0, {WIDTH{1'b1}}};
          guess_d  = midpoint({(WIDTH+1){1'b0}}, {1'b0, {WIDTH{1'b1}}});
          result_d = {WIDTH{1'b0}};
          steps_d  = {SW{1'b0}};
          found_d  = 1'b0;
          error_d  = 1'b0;
          state_d  = S_PROBE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PROBE: begin
        if (cmp_valid) begin
          steps_d = steps_q + SW'(1);
          if (!resp_legal(gt, eq, lt)) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (eq) begin
            result_d = guess_q;
            found_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            if (gt) begin
              lo_d = {1'b0, guess_q} + {{WIDTH{1'b0}}, 1'b1};
            end else begin
              hi_d = {1'b0, guess_q} - {{WIDTH{1'b0}}, 1'b1};
            end
            // A valid hi never has its top bit set, so a set top bit means
            // guess was 0 and hi underflowed to -1: the window is empty.
            if (hi_d[WIDTH] || (lo_d > hi_d)) begin
              state_d = S_DONE;
            end else begin
              guess_d = midpoint(lo_d, hi_d);
              state_d = S_PROBE;
            end
          end
        end else begin
          state_d = S_PROBE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_PROBE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= {(WIDTH+1){1'b0}};
      hi_q     <= {(WIDTH+1){1'b0}};
      guess_q  <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      steps_q  <= {SW{1'b0}};
      found_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      found_q  <= found_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign steps  = steps_q;
  assign found  = found_q;
  assign error  = error_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sar_search.sv
// Testbench for sar_search (WIDTH=3): a behavioural comparator/responder
// feeds the DUT, and an integer binary-search model predicts the probe
// sequence and final status of every search.
module tb_sar_search;

  localparam int W  = 3;
  localparam int SW = $clog2(W + 2);

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  guess;
  logic          cmp_valid;
  logic          gt, eq, lt;
  logic          busy, done, found, error;
  logic [W-1:0]  result;
  logic [SW-1:0] steps;

  // responder: 0 = honest comparator, 1 = gt&lt, 2 = no flags, 3 = always lt
  int target;
  int mode;

  int checks;
  int failures;

  int exp_g[$];
  int exp_found, exp_error, exp_result, exp_steps;
  int prev_found, prev_error, prev_result, prev_steps;

  sar_search #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .guess     (guess),
    .cmp_valid (cmp_valid),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .error     (error),
    .result    (result),
    .steps     (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator / responder on the far side of the DUT.
  always_comb begin
    gt = 1'b0;
    eq = 1'b0;
    lt = 1'b0;
    case (mode)
      0: begin
        gt = (target > int'(guess));
        eq = (target == int'(guess));
        lt = (target < int'(guess));
      end
      1: begin
        gt = 1'b1;
        lt = 1'b1;
      end
      2: begin
        gt = 1'b0;
      end
      default: begin
        lt = 1'b1;
      end
    endcase
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: plain integer binary search over [0, 2^W-1].
  task automatic model(input int tgt, input int md);
    int lo, hi, g;
    exp_g.delete();
    exp_found  = 0;
    exp_error  = 0;
    exp_result = 0;
    exp_steps  = 0;
    lo = 0;
    hi = (1 << W) - 1;
    for (int n = 0; n < 16; n++) begin
      g = (lo + hi) / 2;
      exp_g.push_back(g);
      exp_steps++;
      if (md == 1 || md == 2) begin
        exp_error = 1;
        break;
      end
      if (md == 0 && tgt == g) begin
        exp_found  = 1;
        exp_result = g;
        break;
      end
      if (md == 0 && tgt > g) lo = g + 1;
      else hi = g - 1;
      if (lo > hi) break;
    end
  endtask

  task automatic check_held();
    check("held_found",  found,  prev_found);
    check("held_error",  error,  prev_error);
    check("held_result", result, prev_result);
    check("held_steps",  steps,  prev_steps);
  endtask

  task automatic run_search(input int tgt, input int md, input int st_lo,
                            input int st_hi, input bit hold_start);
    int nst;
    model(tgt, md);
    target = tgt;
    mode   = md;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check_held();
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    for (int i = 0; i < exp_g.size(); i++) begin
      nst = $urandom_range(st_hi, st_lo);
      for (int s = 0; s < nst; s++) begin
        cmp_valid = 1'b0;
        check("stall_guess", guess, exp_g[i]);
        check("stall_busy",  busy,  1);
        check("stall_done",  done,  0);
        @(negedge clk);
      end
      cmp_valid = 1'b1;
      check("probe_guess", guess, exp_g[i]);
      check("probe_busy",  busy,  1);
      check("probe_done",  done,  0);
      @(negedge clk);
    end
    cmp_valid = 1'b0;
    start     = 1'b0;
    check("end_done",   done,   1);
    check("end_busy",   busy,   0);
    check("end_found",  found,  exp_found);
    check("end_error",  error,  exp_error);
    check("end_result", result, exp_result);
    check("end_steps",  steps,  exp_steps);
    prev_found  = exp_found;
    prev_error  = exp_error;
    prev_result = exp_result;
    prev_steps  = exp_steps;
  endtask

  task automatic check_reset_outputs();
    check("rst_guess",  guess,  0);
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_found",  found,  0);
    check("rst_error",  error,  0);
    check("rst_result", result, 0);
    check("rst_steps",  steps,  0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    cmp_valid = 1'b0;
    target    = 0;
    mode      = 0;
    prev_found = 0; prev_error = 0; prev_result = 0; prev_steps = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // directed targets from the plan
    run_search(5, 0, 0, 0, 1'b0);
    run_search(7, 0, 0, 0, 1'b0);
    run_search(0, 0, 0, 0, 1'b0);

    // sweep: every target found within W+1 steps
    for (int t = 0; t < (1 << W); t++) begin
      run_search(t, 0, 0, 0, 1'b0);
      check("sweep_bound", (int'(steps) <= W + 1), 1);
    end

    // responder stalls of exactly 5 cycles before each response
    run_search(5, 0, 5, 5, 1'b0);
    run_search(7, 0, 5, 5, 1'b0);

    // illegal responses and an inconsistent responder
    run_search(5, 1, 0, 0, 1'b0);
    run_search(2, 2, 0, 0, 1'b0);
    run_search(4, 3, 0, 0, 1'b0);

    // start held high throughout the search
    run_search(6, 0, 0, 2, 1'b1);

    // reset on the second probe
    model(5, 0);
    target = 5;
    mode   = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cmp_valid = 1'b1;
    @(negedge clk);
    check("pre_rst_guess", guess, exp_g[1]);
    rst       = 1'b1;
    cmp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();
    @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);
    prev_found = 0; prev_error = 0; prev_result = 0; prev_steps = 0;
    run_search(5, 0, 0, 0, 1'b0);

    // randomized targets, stalls and start holding
    for (int r = 0; r < 24; r++) begin
      run_search($urandom_range((1 << W) - 1, 0), 0, 0, 3, 1'($urandom_range(1, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
